// File: rtl/id_scoreboard_if.sv
// Decode-stage scoreboard bus: ID handshake, operand reads, forward sources,
// retire/squash events and resolved operands.
interface id_scoreboard_if #(
    parameter int XLEN          = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int FWD_PORTS     = 3,
    parameter int KILL_PORTS    = 2
);
    logic                                 id_valid_i;
    logic                                 id_ready_o;
    logic                                 ex_ready_i;
    logic                                 id_issue_o;
    logic [REG_IDX_WIDTH-1:0]             id_rs1_idx_i;
    logic                                 id_rs1_en_i;
    logic [REG_IDX_WIDTH-1:0]             id_rs2_idx_i;
    logic                                 id_rs2_en_i;
    logic [REG_IDX_WIDTH-1:0]             id_rd_idx_i;
    logic                                 id_rd_en_i;
    logic [XLEN-1:0]                      rs1_rdata_i;
    logic [XLEN-1:0]                      rs2_rdata_i;
    logic [FWD_PORTS-1:0]                 fwd_en_i;
    logic [FWD_PORTS*REG_IDX_WIDTH-1:0]   fwd_idx_i;
    logic [FWD_PORTS-1:0]                 fwd_vld_i;
    logic [FWD_PORTS*XLEN-1:0]            fwd_data_i;
    logic                                 wb_en_i;
    logic [REG_IDX_WIDTH-1:0]             wb_idx_i;
    logic [KILL_PORTS-1:0]                kill_en_i;
    logic [KILL_PORTS*REG_IDX_WIDTH-1:0]  kill_idx_i;
    logic [XLEN-1:0]                      id_rs1_rdata_o;
    logic [XLEN-1:0]                      id_rs2_rdata_o;
    logic                                 id_stall_o;
    logic                                 sb_err_o;
    logic [31:0]                          stall_cnt_o;

    modport master (
        output id_valid_i, ex_ready_i, id_rs1_idx_i, id_rs1_en_i, id_rs2_idx_i, id_rs2_en_i,
               id_rd_idx_i, id_rd_en_i, rs1_rdata_i, rs2_rdata_i, fwd_en_i, fwd_idx_i,
               fwd_vld_i, fwd_data_i, wb_en_i, wb_idx_i, kill_en_i, kill_idx_i,
        input  id_ready_o, id_issue_o, id_rs1_rdata_o, id_rs2_rdata_o, id_stall_o,
               sb_err_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, ex_ready_i, id_rs1_idx_i, id_rs1_en_i, id_rs2_idx_i, id_rs2_en_i,
               id_rd_idx_i, id_rd_en_i, rs1_rdata_i, rs2_rdata_i, fwd_en_i, fwd_idx_i,
               fwd_vld_i, fwd_data_i, wb_en_i, wb_idx_i, kill_en_i, kill_idx_i,
        output id_ready_o, id_issue_o, id_rs1_rdata_o, id_rs2_rdata_o, id_stall_o,
               sb_err_o, stall_cnt_o
    );
endinterface

// File: rtl/id_scoreboard.sv
// Decode-stage hazard unit: per-register pending-write counters, operand
// forwarding from FWD_PORTS sources (port 0 youngest, last port = WB),
// RAW stall generation and a saturating stall-cycle counter.
module id_scoreboard #(
    parameter int XLEN          = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int FWD_PORTS     = 3,
    parameter int KILL_PORTS    = 2,
    parameter int CNT_WIDTH     = 2
) (
    input logic              clk,
    input logic              rst_n,
    id_scoreboard_if.slave   bus
);
    localparam int W    = REG_IDX_WIDTH;
    localparam int NREG = 2 ** REG_IDX_WIDTH;
    localparam int SW   = 16;  // wide enough for cnt + 1 and wb + all kill ports
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q [NREG];
    logic [CNT_WIDTH-1:0] cnt_d [NREG];
    logic                 err_q, err_d;
    logic [31:0]          stall_cnt_q;

    logic [FWD_PORTS-1:0]        fwd_en, fwd_vld;
    logic [FWD_PORTS*W-1:0]      fwd_idx;
    logic [FWD_PORTS*XLEN-1:0]   fwd_data;
    logic [XLEN:0]               rs1_res, rs2_res;
    logic                        rd_full, hazard, issue, stall;

    assign fwd_en   = bus.fwd_en_i;
    assign fwd_vld  = bus.fwd_vld_i;
    assign fwd_idx  = bus.fwd_idx_i;
    assign fwd_data = bus.fwd_data_i;

    // Returns {hazard, data}; the lowest-numbered matching source wins, an
    // unresolved in-flight producer (counter non-zero) stalls.
    function automatic logic [XLEN:0] resolve(input logic en, input logic [W-1:0] idx,
                                              input logic [XLEN-1:0] rf);
        logic            hit;
        logic            haz;
        logic [XLEN-1:0] data;
        hit  = 1'b0;
        haz  = 1'b0;
        data = rf;
        if (en && idx != '0) begin
            for (int i = 0; i < FWD_PORTS; i++) begin
                if (!hit && fwd_en[i] && fwd_idx[i*W +: W] == idx) begin
                    hit = 1'b1;
                    if (fwd_vld[i]) data = fwd_data[i*XLEN +: XLEN];
                    else            haz  = 1'b1;
                end
            end
            if (!hit && cnt_q[idx] != '0) haz = 1'b1;
        end
        return {haz, data};
    endfunction

    // Operand resolution, stall and issue handshake.
    always_comb begin
        rs1_res = resolve(bus.id_rs1_en_i, bus.id_rs1_idx_i, bus.rs1_rdata_i);
        rs2_res = resolve(bus.id_rs2_en_i, bus.id_rs2_idx_i, bus.rs2_rdata_i);
        rd_full = bus.id_rd_en_i && bus.id_rd_idx_i != '0 && cnt_q[bus.id_rd_idx_i] == CNT_MAX;
        hazard  = rs1_res[XLEN] | rs2_res[XLEN] | rd_full;
        stall   = bus.id_valid_i & hazard;
        issue   = bus.id_valid_i & bus.ex_ready_i & ~hazard;
    end

    assign bus.id_ready_o     = bus.ex_ready_i & ~hazard;
    assign bus.id_issue_o     = issue;
    assign bus.id_stall_o     = stall;
    assign bus.id_rs1_rdata_o = rs1_res[XLEN-1:0];
    assign bus.id_rs2_rdata_o = rs2_res[XLEN-1:0];
    assign bus.sb_err_o       = err_q;
    assign bus.stall_cnt_o    = stall_cnt_q;

    // Next pending count per register: add the issuing write, subtract all
    // retire/squash events together; an underflow clamps to 0 and flags error.
    always_comb begin
        logic [SW-1:0] sum;
        logic [SW-1:0] dec;
        sum      = '0;
        dec      = '0;
        err_d    = err_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            sum = SW'(cnt_q[r]) + SW'(issue && bus.id_rd_en_i && bus.id_rd_idx_i == W'(r));
            dec = SW'(bus.wb_en_i && bus.wb_idx_i == W'(r));
            for (int k = 0; k < KILL_PORTS; k++)
                dec = dec + SW'(bus.kill_en_i[k] && bus.kill_idx_i[k*W +: W] == W'(r));
            if (dec > sum) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNT_WIDTH'(sum - dec);
            end
        end
    end

    // Pending counters, sticky error and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
            if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
endmodule
